// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU controller: FSM state encoding,
// PSR flag bit positions and the 8-bit opcodes understood by the external ALU.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int FLAG_Z = 4;
  localparam int FLAG_C = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_N = 0;

  localparam logic [7:0] OP_NOP     = 8'h00;
  localparam logic [7:0] OP_AND     = 8'h01;
  localparam logic [7:0] OP_OR      = 8'h02;
  localparam logic [7:0] OP_XOR     = 8'h03;
  localparam logic [7:0] OP_ADDCU   = 8'h04;
  localparam logic [7:0] OP_ADD     = 8'h05;
  localparam logic [7:0] OP_ADDU    = 8'h06;
  localparam logic [7:0] OP_ADDC    = 8'h07;
  localparam logic [7:0] OP_SUB     = 8'h09;
  localparam logic [7:0] OP_SUBC    = 8'h0A;
  localparam logic [7:0] OP_CMP     = 8'h0B;
  localparam logic [7:0] OP_MOV     = 8'h0D;
  localparam logic [7:0] OP_CMPU    = 8'h0E;
  localparam logic [7:0] OP_ANDI    = 8'h10;
  localparam logic [7:0] OP_ORI     = 8'h20;
  localparam logic [7:0] OP_XORI    = 8'h30;
  localparam logic [7:0] OP_ADDI    = 8'h50;
  localparam logic [7:0] OP_ADDUI   = 8'h60;
  localparam logic [7:0] OP_ADDCI   = 8'h70;
  localparam logic [7:0] OP_LSHI_L  = 8'h80;
  localparam logic [7:0] OP_LSHI_R  = 8'h81;
  localparam logic [7:0] OP_ASHUI_L = 8'h82;
  localparam logic [7:0] OP_ASHUI_R = 8'h83;
  localparam logic [7:0] OP_LSH     = 8'h84;
  localparam logic [7:0] OP_ASHU    = 8'h86;
  localparam logic [7:0] OP_SUBI    = 8'h90;
  localparam logic [7:0] OP_SUBCI   = 8'hA0;
  localparam logic [7:0] OP_CMPI    = 8'hB0;
  localparam logic [7:0] OP_MOVI    = 8'hD0;
  localparam logic [7:0] OP_CMPUI   = 8'hE0;

  // Compare instructions only update flags; they never write Rd.
  function automatic logic is_compare(input logic [7:0] opc);
    return (opc == OP_CMP) || (opc == OP_CMPU) ||
           (opc == OP_CMPI) || (opc == OP_CMPUI);
  endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: maps the 16-bit instruction word onto the
// ALU opcode and the control bits the sequencer needs.
// Op 0000 and op 1000 carry their sub-function in ext; every other op is an
// immediate form whose low byte is the immediate. Op 1000 with ext 00xx is a
// shift by the 4-bit constant held in rs_imm.
module alu_seq_decode
  import alu_seq_pkg::*;
(
  input  logic [15:0] inst,
  output logic [7:0]  alu_opcode,
  output logic        imm_sel,
  output logic        imm_sign,
  output logic        writes_rd,
  output logic        writes_psr,
  output logic        legal
);

  logic [3:0] op;
  logic [3:0] ext;
  logic       reg_form;
  logic       shift_imm;

  assign op  = inst[15:12];
  assign ext = inst[7:4];

  // Form selection, opcode assembly and legality check of the latched word.
  always_comb begin
    reg_form   = (op == 4'h0) || (op == 4'h8);
    shift_imm  = (op == 4'h8) && (ext[3:2] == 2'b00);
    alu_opcode = reg_form ? {op, ext} : {op, 4'h0};
    imm_sel    = !reg_form || shift_imm;
    imm_sign   = (alu_opcode == OP_ADDI) || (alu_opcode == OP_ADDCI) ||
                 (alu_opcode == OP_SUBI) || (alu_opcode == OP_CMPI);
    case (alu_opcode)
      OP_NOP, OP_AND, OP_OR, OP_XOR, OP_ADDCU, OP_ADD, OP_ADDU, OP_ADDC,
      OP_SUB, OP_SUBC, OP_CMP, OP_MOV, OP_CMPU,
      OP_ANDI, OP_ORI, OP_XORI, OP_ADDI, OP_ADDUI, OP_ADDCI,
      OP_SUBI, OP_SUBCI, OP_CMPI, OP_MOVI, OP_CMPUI,
      OP_LSHI_L, OP_LSHI_R, OP_ASHUI_L, OP_ASHUI_R, OP_LSH, OP_ASHU:
        legal = 1'b1;
      default:
        legal = 1'b0;
    endcase
    writes_psr = legal && (alu_opcode != OP_NOP);
    writes_rd  = writes_psr && !is_compare(alu_opcode);
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential controller for an external combinational ALU. Each accepted
// instruction walks IDLE -> READ -> EXEC -> WB, reading two registers,
// driving the ALU, then writing Rd and the PSR on the way back to IDLE.
// Optional feature: define ALU_SEQ_PERF_COUNT_EN to add the 16-bit
// retired_cnt output counting every retired instruction.
module alu_seq
  import alu_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_inst,
  output logic        in_ready,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  input  logic [15:0] rf_ra_data,
  input  logic [15:0] rf_rb_data,
  output logic        rf_we,
  output logic [3:0]  rf_wa,
  output logic [15:0] rf_wd,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [7:0]  alu_opcode,
  output logic        alu_carry_in,
  input  logic [15:0] alu_c,
  input  logic [4:0]  alu_flags,
  output logic [4:0]  psr,
  output logic        done,
  output logic        illegal
`ifdef ALU_SEQ_PERF_COUNT_EN
  ,
  output logic [15:0] retired_cnt
`endif
);

  state_t      state;
  state_t      next_state;
  logic [15:0] inst_q;
  logic [15:0] ra_q;
  logic [15:0] rb_q;
  logic [15:0] c_q;
  logic [4:0]  flags_q;
  logic [15:0] imm_val;
  logic [15:0] operand_b;
  logic        accept;

  logic [7:0]  dec_opcode;
  logic        dec_imm_sel;
  logic        dec_imm_sign;
  logic        dec_writes_rd;
  logic        dec_writes_psr;
  logic        dec_legal;

  assign accept = in_valid && (state == ST_IDLE);

  alu_seq_decode u_decode (
    .inst       (inst_q),
    .alu_opcode (dec_opcode),
    .imm_sel    (dec_imm_sel),
    .imm_sign   (dec_imm_sign),
    .writes_rd  (dec_writes_rd),
    .writes_psr (dec_writes_psr),
    .legal      (dec_legal)
  );

  // Build the second ALU operand: shift constant, sign/zero-extended byte, or Rs.
  always_comb begin
    if (dec_opcode[7:4] == 4'h8) begin
      imm_val = {12'h000, inst_q[3:0]};
    end else if (dec_imm_sign) begin
      imm_val = {{8{inst_q[7]}}, inst_q[7:0]};
    end else begin
      imm_val = {8'h00, inst_q[7:0]};
    end
    operand_b = dec_imm_sel ? imm_val : rb_q;
  end

  // State register; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and all per-state outputs; everything idles at zero.
  always_comb begin
    next_state   = state;
    in_ready     = 1'b0;
    rf_ra_addr   = 4'h0;
    rf_rb_addr   = 4'h0;
    rf_we        = 1'b0;
    rf_wa        = 4'h0;
    rf_wd        = 16'h0000;
    alu_a        = 16'h0000;
    alu_b        = 16'h0000;
    alu_opcode   = 8'h00;
    alu_carry_in = 1'b0;
    done         = 1'b0;
    illegal      = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          next_state = ST_READ;
        end
      end
      ST_READ: begin
        rf_ra_addr = inst_q[11:8];
        rf_rb_addr = inst_q[3:0];
        next_state = ST_EXEC;
      end
      ST_EXEC: begin
        alu_a        = ra_q;
        alu_b        = operand_b;
        alu_opcode   = dec_opcode;
        alu_carry_in = psr[FLAG_C];
        next_state   = ST_WB;
      end
      ST_WB: begin
        rf_we = dec_writes_rd;
        if (dec_writes_rd) begin
          rf_wa = inst_q[11:8];
          rf_wd = c_q;
        end
        done       = 1'b1;
        illegal    = !dec_legal;
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Datapath latches: instruction on accept, operands after READ,
  // ALU result after EXEC, PSR on the WB edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      inst_q  <= 16'h0000;
      ra_q    <= 16'h0000;
      rb_q    <= 16'h0000;
      c_q     <= 16'h0000;
      flags_q <= 5'h00;
      psr     <= 5'h00;
    end else begin
      if (accept) begin
        inst_q <= in_inst;
      end
      if (state == ST_READ) begin
        ra_q <= rf_ra_data;
        rb_q <= rf_rb_data;
      end
      if (state == ST_EXEC) begin
        c_q     <= alu_c;
        flags_q <= alu_flags;
      end
      if ((state == ST_WB) && dec_writes_psr) begin
        psr <= flags_q;
      end
    end
  end

`ifdef ALU_SEQ_PERF_COUNT_EN
  // Count every retire, illegal ones included; wraps naturally at 16 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      retired_cnt <= 16'h0000;
    end else if (state == ST_WB) begin
      retired_cnt <= retired_cnt + 16'h0001;
    end
  end
`else
  // Default build carries no retire counter.
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: behavioural ALU and register file around
// the DUT, directed scenarios followed by random instructions, all checked
// against an instruction-level reference model.
module tb_alu_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] in_inst;
  logic        in_ready;
  logic [3:0]  rf_ra_addr;
  logic [3:0]  rf_rb_addr;
  logic [15:0] rf_ra_data;
  logic [15:0] rf_rb_data;
  logic        rf_we;
  logic [3:0]  rf_wa;
  logic [15:0] rf_wd;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic        alu_carry_in;
  logic [15:0] alu_c;
  logic [4:0]  alu_flags;
  logic [4:0]  psr;
  logic        done;
  logic        illegal;
`ifdef ALU_SEQ_PERF_COUNT_EN
  logic [15:0] retired_cnt;
`endif

  int num_compared   = 0;
  int num_mismatched = 0;

  logic [15:0] rf [16];
  logic [15:0] mregs [16];
  logic [4:0]  mpsr = 5'h00;
  int          mretired = 0;

  logic [7:0] legal_keys [30] = '{
    8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A,
    8'h0B, 8'h0D, 8'h0E, 8'h80, 8'h81, 8'h82, 8'h83, 8'h84, 8'h86, 8'h10,
    8'h20, 8'h30, 8'h50, 8'h60, 8'h70, 8'h90, 8'hA0, 8'hB0, 8'hD0, 8'hE0};

  alu_seq dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_inst      (in_inst),
    .in_ready     (in_ready),
    .rf_ra_addr   (rf_ra_addr),
    .rf_rb_addr   (rf_rb_addr),
    .rf_ra_data   (rf_ra_data),
    .rf_rb_data   (rf_rb_data),
    .rf_we        (rf_we),
    .rf_wa        (rf_wa),
    .rf_wd        (rf_wd),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_carry_in (alu_carry_in),
    .alu_c        (alu_c),
    .alu_flags    (alu_flags),
    .psr          (psr),
    .done         (done),
    .illegal      (illegal)
`ifdef ALU_SEQ_PERF_COUNT_EN
    ,
    .retired_cnt  (retired_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: returns {flags Z,C,F,L,N, result}.
  function automatic logic [20:0] alu_fn(input logic [7:0] opc, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] wide;
    logic [15:0] c;
    logic [4:0]  f;
    logic        cmp;
    wide = '0; c = '0; f = '0; cmp = 1'b0;
    case (opc)
      8'h01, 8'h10: c = a & b;
      8'h02, 8'h20: c = a | b;
      8'h03, 8'h30: c = a ^ b;
      8'h04, 8'h05, 8'h06, 8'h07, 8'h50, 8'h60, 8'h70: begin
        wide = {1'b0, a} + {1'b0, b} +
               ((opc == 8'h04 || opc == 8'h07 || opc == 8'h70) ? {16'h0, cin} : 17'h0);
        c = wide[15:0];
        f[3] = wide[16];
        f[2] = (a[15] == b[15]) && (c[15] != a[15]);
      end
      8'h09, 8'h0A, 8'h90, 8'hA0: begin
        wide = {1'b0, a} - {1'b0, b} -
               ((opc == 8'h0A || opc == 8'hA0) ? {16'h0, cin} : 17'h0);
        c = wide[15:0];
        f[3] = wide[16];
        f[2] = (a[15] != b[15]) && (c[15] != a[15]);
      end
      8'h0B, 8'h0E, 8'hB0, 8'hE0: begin
        cmp = 1'b1;
        f[1] = a < b;
        f[0] = $signed(a) < $signed(b);
      end
      8'h0D, 8'hD0: c = b;
      8'h80, 8'h82, 8'h84: c = a << b[3:0];
      8'h81: c = a >> b[3:0];
      8'h83, 8'h86: c = $signed(a) >>> b[3:0];
      default: c = 16'h0000;
    endcase
    f[4] = cmp ? (a == b) : (c == 16'h0000);
    return {f, c};
  endfunction

  always_comb {alu_flags, alu_c} = alu_fn(alu_opcode, alu_a, alu_b, alu_carry_in);

  assign rf_ra_data = rf[rf_ra_addr];
  assign rf_rb_data = rf[rf_rb_addr];

  // Register file write port.
  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] <= rf_wd;
  end

  // Instruction-level view of decoding: which ALU operation and which operand.
  function automatic void modelDecode(input logic [15:0] w, output logic [7:0] key,
                                      output logic use_imm, output logic [15:0] imm,
                                      output logic ok);
    logic [3:0] op;
    logic [3:0] ext;
    op = w[15:12];
    ext = w[7:4];
    if (op == 4'h8 && ext < 4'h4) begin
      key = {op, ext}; use_imm = 1'b1; imm = {12'h000, w[3:0]};
    end else if (op == 4'h0 || op == 4'h8) begin
      key = {op, ext}; use_imm = 1'b0; imm = 16'h0000;
    end else begin
      key = {op, 4'h0}; use_imm = 1'b1;
      if (key == 8'h50 || key == 8'h70 || key == 8'h90 || key == 8'hB0)
        imm = {{8{w[7]}}, w[7:0]};
      else
        imm = {8'h00, w[7:0]};
    end
    ok = 1'b0;
    foreach (legal_keys[i]) if (legal_keys[i] == key) ok = 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    num_compared++;
    if (actual !== expected) begin
      num_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic setReg(input int idx, input logic [15:0] val);
    rf[idx] = val;
    mregs[idx] = val;
  endtask

  // Issue one instruction and follow it through every stage.
  task automatic applyStimulus(input logic [15:0] w);
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [7:0]  key;
    logic        use_imm;
    logic        ok;
    logic        upd;
    logic        writes;
    logic [15:0] imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [20:0] r;
    int          guard;
    rd = w[11:8];
    rs = w[3:0];
    modelDecode(w, key, use_imm, imm, ok);
    a = mregs[rd];
    b = use_imm ? imm : mregs[rs];
    r = alu_fn(key, a, b, mpsr[3]);
    upd = ok && (key != 8'h00);
    writes = upd && !(key == 8'h0B || key == 8'h0E || key == 8'hB0 || key == 8'hE0);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("idle_ready", {31'h0, in_ready}, 32'h1);
    in_valid = 1'b1;
    in_inst = w;
    @(posedge clk);
    #1;
    in_inst = 16'($urandom);
    in_valid = 1'($urandom_range(0, 1));
    @(negedge clk);
    checkOutput("read_ra_addr", {28'h0, rf_ra_addr}, {28'h0, rd});
    checkOutput("read_rb_addr", {28'h0, rf_rb_addr}, {28'h0, rs});
    checkOutput("read_ready", {31'h0, in_ready}, 32'h0);
    checkOutput("read_done", {31'h0, done}, 32'h0);
    @(negedge clk);
    checkOutput("exec_opcode", {24'h0, alu_opcode}, {24'h0, key});
    checkOutput("exec_a", {16'h0, alu_a}, {16'h0, a});
    checkOutput("exec_b", {16'h0, alu_b}, {16'h0, b});
    checkOutput("exec_cin", {31'h0, alu_carry_in}, {31'h0, mpsr[3]});
    checkOutput("exec_we", {31'h0, rf_we}, 32'h0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("wb_we", {31'h0, rf_we}, {31'h0, writes});
    if (writes) begin
      checkOutput("wb_wa", {28'h0, rf_wa}, {28'h0, rd});
      checkOutput("wb_wd", {16'h0, rf_wd}, {16'h0, r[15:0]});
    end
    checkOutput("wb_done", {31'h0, done}, 32'h1);
    checkOutput("wb_illegal", {31'h0, illegal}, {31'h0, !ok});
    if (writes) mregs[rd] = r[15:0];
    if (upd) mpsr = r[20:16];
    mretired++;
    @(negedge clk);
    checkOutput("post_psr", {27'h0, psr}, {27'h0, mpsr});
    checkOutput("post_done", {31'h0, done}, 32'h0);
    checkOutput("post_illegal", {31'h0, illegal}, 32'h0);
    checkOutput("post_rd", {16'h0, rf[rd]}, {16'h0, mregs[rd]});
  endtask

  // Outputs expected right after a reset edge.
  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, {31'h0, in_ready}, 32'h1);
    checkOutput({tag, "_psr"}, {27'h0, psr}, 32'h0);
    checkOutput({tag, "_we"}, {31'h0, rf_we}, 32'h0);
    checkOutput({tag, "_done"}, {31'h0, done}, 32'h0);
    checkOutput({tag, "_illegal"}, {31'h0, illegal}, 32'h0);
    checkOutput({tag, "_alu"}, {alu_a, alu_b}, 32'h0);
    checkOutput({tag, "_aluop"}, {23'h0, alu_opcode, alu_carry_in}, 32'h0);
    checkOutput({tag, "_rfaddr"}, {20'h0, rf_ra_addr, rf_rb_addr, rf_wa}, 32'h0);
    checkOutput({tag, "_wd"}, {16'h0, rf_wd}, 32'h0);
  endtask

  initial begin
    logic [15:0] w;
    logic [7:0]  k;
    reset = 1'b1;
    in_valid = 1'b0;
    in_inst = 16'h0000;
    for (int i = 0; i < 16; i++) setReg(i, 16'($urandom));
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkResetState("reset");

    // ADD overflow: 0x7FFF + 1
    setReg(1, 16'h7FFF);
    setReg(2, 16'h0001);
    applyStimulus(16'h0152);
    checkOutput("add_r1", {16'h0, rf[1]}, 32'h8000);
    checkOutput("add_psr", {27'h0, psr}, 32'h04);

    // ADDI with sign-extended 0xFF
    setReg(3, 16'h0005);
    applyStimulus(16'h53FF);
    checkOutput("addi_r3", {16'h0, rf[3]}, 32'h0004);

    // CMP 2 vs 7: L and N only
    setReg(4, 16'h0002);
    setReg(5, 16'h0007);
    applyStimulus(16'h04B5);
    checkOutput("cmp_psr", {27'h0, psr}, 32'h03);
    checkOutput("cmp_r4", {16'h0, rf[4]}, 32'h0002);

    // Set carry with 0xFFFF + 1, then ADDCU consumes it
    setReg(8, 16'hFFFF);
    setReg(9, 16'h0001);
    applyStimulus(16'h0859);
    checkOutput("carry_psr", {27'h0, psr}, 32'h18);
    setReg(6, 16'h0001);
    setReg(7, 16'h0000);
    applyStimulus(16'h0647);
    checkOutput("addcu_r6", {16'h0, rf[6]}, 32'h0002);

    // Illegal opcode 0xF0, NOP, same-register operands, shift immediate
    applyStimulus(16'hF305);
    applyStimulus(16'h0000);
    setReg(10, 16'h1234);
    applyStimulus(16'h0A5A);
    checkOutput("same_reg", {16'h0, rf[10]}, 32'h2468);
    setReg(11, 16'h0003);
    applyStimulus(16'h8B24);
    checkOutput("shift_imm", {16'h0, rf[11]}, 32'h0030);

    // Reset during EXEC of an ADD
    setReg(1, 16'h0100);
    setReg(2, 16'h0011);
    in_valid = 1'b1;
    in_inst = 16'h0152;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkResetState("midreset");
    mpsr = 5'h00;
    mretired = 0;
    @(negedge clk);
    checkOutput("midreset_we2", {31'h0, rf_we}, 32'h0);
    checkOutput("midreset_done2", {31'h0, done}, 32'h0);
    checkOutput("midreset_r1", {16'h0, rf[1]}, 32'h0100);

    // Random instruction mix
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        w = 16'($urandom);
      end else begin
        k = legal_keys[$urandom_range(0, 29)];
        if (k[7:4] == 4'h0 || k[7:4] == 4'h8)
          w = {k[7:4], 4'($urandom), k[3:0], 4'($urandom)};
        else
          w = {k[7:4], 4'($urandom), 8'($urandom)};
      end
      applyStimulus(w);
    end

`ifdef ALU_SEQ_PERF_COUNT_EN
    checkOutput("retired_cnt", {16'h0, retired_cnt}, 32'(mretired));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
    $finish;
  end

endmodule
